// File: rtl/spi_master_tx_if.sv
// Signal bundle between the SPI master transmitter and its user/bus side.
// The master modport is the transmitter's view; the slave modport is the requester/slave view.
interface spi_master_tx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              miso_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk_out;
  logic              mosi_out;
  logic              ss_n_out;

  modport master (
    input  start, tx_data, miso_in,
    output busy, done, rx_data, sclk_out, mosi_out, ss_n_out
  );

  modport slave (
    output start, tx_data, miso_in,
    input  busy, done, rx_data, sclk_out, mosi_out, ss_n_out
  );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master, MSB first, full duplex: one DATA_W-bit frame per accepted start pulse.
// SCLK half-period is CLK_DIV system clocks; outputs are decoded directly from registered state.
module spi_master_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input logic           clk,
  input logic           reset,
  spi_master_tx_if.master bus
);
  localparam int unsigned CntW = $clog2(CLK_DIV) + 1;
  localparam int unsigned BitW = $clog2(DATA_W) + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StHigh  = 3'd2;
  localparam logic [2:0] StLow   = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              phase_end;
  logic              in_frame;

  assign phase_end = (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = phase_end ? '0 : cnt_q + CntW'(1);
    bit_d      = bit_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    rx_d       = rx_q;
    unique case (state_q)
      StIdle, StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
        // DONE also accepts start so back-to-back frames leave ss_n high for one cycle.
        if (bus.start) begin
          state_d    = StSetup;
          shift_tx_d = bus.tx_data;
          shift_rx_d = '0;
          bit_d      = '0;
        end
      end
      StSetup, StLow: begin
        if (phase_end) begin
          state_d    = StHigh;
          shift_rx_d = {shift_rx_q[DATA_W-2:0], bus.miso_in};
        end
      end
      StHigh: begin
        if (phase_end) begin
          bit_d = bit_q + BitW'(1);
          if (bit_q == BitW'(DATA_W - 1)) begin
            state_d = StHold;
          end else begin
            state_d    = StLow;
            shift_tx_d = {shift_tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      StHold: begin
        if (phase_end) begin
          state_d = StDone;
          rx_d    = shift_rx_q;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      rx_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      rx_q       <= rx_d;
    end
  end

  assign in_frame     = (state_q == StSetup) || (state_q == StHigh) ||
                        (state_q == StLow)   || (state_q == StHold);
  assign bus.busy     = in_frame;
  assign bus.ss_n_out = ~in_frame;
  assign bus.sclk_out = (state_q == StHigh);
  assign bus.done     = (state_q == StDone);
  assign bus.mosi_out = in_frame & shift_tx_q[DATA_W-1];
  assign bus.rx_data  = rx_q;
endmodule

// File: tb/tb_spi_master_tx.sv
// Randomized bench for spi_master_tx: a frame-offset model checks every output each cycle,
// with literal expectations pinning latency, loopback data and edge counts.
module tb_spi_master_tx;
  localparam int W     = 8;
  localparam int DA    = 2;
  localparam int DB    = 1;
  localparam int KDONE = 1 + (2 * W + 1) * DA;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_master_tx_if #(.DATA_W(W)) sa ();
  spi_master_tx_if #(.DATA_W(W)) sb ();

  spi_master_tx #(.DATA_W(W), .CLK_DIV(DA)) u_dut_a (.clk(clk), .reset(rst), .bus(sa));
  spi_master_tx #(.DATA_W(W), .CLK_DIV(DB)) u_dut_b (.clk(clk), .reset(rst), .bus(sb));

  int   nvec = 0;
  int   nerr = 0;
  logic chk_en = 1'b0;
  int   mode = 0;        // 0 loopback, 1 constant, 2 random miso
  logic const_bit = 1'b0;
  logic rnd_bit = 1'b0;

  assign sa.miso_in = (mode == 0) ? sa.mosi_out : (mode == 1) ? const_bit : rnd_bit;
  assign sb.miso_in = sb.mosi_out;

  always @(negedge clk) rnd_bit <= 1'($urandom);

  int rises_a = 0, rises_b = 0, ndone_a = 0;
  always @(posedge sa.sclk_out) rises_a <= rises_a + 1;
  always @(posedge sb.sclk_out) rises_b <= rises_b + 1;
  always @(negedge clk) if (sa.done) ndone_a <= ndone_a + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mk is the cycle offset within a frame (0 = idle, 1 = first SETUP cycle, KDONE = DONE).
  int           mk = 0;
  logic [W-1:0] mtx = '0;
  logic [W-1:0] macc = '0;
  logic [W-1:0] mrx = '0;

  always @(posedge clk or posedge rst) begin : model
    int kc;
    int nk;
    if (rst) begin
      mk   <= 0;
      mrx  <= '0;
      macc <= '0;
    end else begin
      kc = mk;
      // MISO is sampled on the edge that starts each HIGH phase, bit j at offset (2j+1)*DA.
      if (kc != 0 && kc < KDONE && (kc % (2 * DA)) == DA)
        macc[W - 1 - (kc - DA) / (2 * DA)] <= sa.miso_in;
      if ((kc == 0 || kc == KDONE) && sa.start) begin
        nk = 1;
        mtx <= sa.tx_data;
      end else if (kc == KDONE || kc == 0) begin
        nk = 0;
      end else begin
        nk = kc + 1;
      end
      if (nk == KDONE) mrx <= macc;
      if (nk == KDONE && kc == KDONE - 1 && ((kc % (2 * DA)) == DA)) mrx <= macc;
      mk <= nk;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_ssn, e_busy, e_done, e_sclk, e_mosi;
      int p, b;
      e_ssn = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0;
      if (mk == KDONE) begin
        e_done = 1'b1;
      end else if (mk != 0) begin
        p = (mk - 1) / DA;
        b = (p / 2 > W - 1) ? W - 1 : p / 2;
        e_ssn  = 1'b0;
        e_busy = 1'b1;
        e_sclk = 1'(p % 2);
        e_mosi = mtx[W - 1 - b];
      end
      chk("ss_n", 32'(sa.ss_n_out), 32'(e_ssn));
      chk("busy", 32'(sa.busy), 32'(e_busy));
      chk("done", 32'(sa.done), 32'(e_done));
      chk("sclk", 32'(sa.sclk_out), 32'(e_sclk));
      chk("mosi", 32'(sa.mosi_out), 32'(e_mosi));
      chk("rx_data", 32'(sa.rx_data), 32'(mrx));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [W-1:0] d);
    sa.tx_data = d;
    sa.start   = 1'b1;
    step();
    sa.start   = 1'b0;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (!sa.done && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, r0, d0, r;
    sa.start = 1'b0; sa.tx_data = '0;
    sb.start = 1'b0; sb.tx_data = '0;
    #1 rst = 1'b1;
    #2 chk_en = 1'b1;
    chk("rst_ss_n", 32'(sa.ss_n_out), 32'd1);
    chk("rst_busy", 32'(sa.busy), 32'd0);
    chk("rst_rx", 32'(sa.rx_data), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Loopback 0xA5: done 34 edges after the accept edge, 8 sclk rises.
    mode = 0;
    r0 = rises_a;
    start_a(8'hA5);
    wait_done_a(n);
    chk("t1_latency", 32'(n), 32'd34);
    chk("t1_rx", 32'(sa.rx_data), 32'hA5);
    chk("t1_rises", 32'(rises_a - r0), 32'd8);
    step(); step();

    // MISO held at 1, sending zeros.
    mode = 1; const_bit = 1'b1;
    start_a(8'h00);
    wait_done_a(n);
    chk("t2_latency", 32'(n), 32'd34);
    chk("t2_rx", 32'(sa.rx_data), 32'hFF);
    step();

    // Mid-frame start and tx_data change are ignored.
    mode = 0;
    d0 = ndone_a;
    start_a(8'h81);
    repeat (10) step();
    sa.tx_data = 8'h3C;
    sa.start   = 1'b1;
    step();
    sa.start   = 1'b0;
    wait_done_a(n);
    chk("t3_latency", 32'(n), 32'd23);
    chk("t3_rx", 32'(sa.rx_data), 32'h81);
    repeat (40) step();
    chk("t3_ndone", 32'(ndone_a - d0), 32'd1);
    chk("t3_idle", 32'(sa.busy), 32'd0);

    // Start held high: back-to-back frames, tx_data swapped in the DONE cycle.
    sa.tx_data = 8'h12;
    sa.start   = 1'b1;
    step();
    wait_done_a(n);
    chk("t4_rx1", 32'(sa.rx_data), 32'h12);
    chk("t4_ssn_done", 32'(sa.ss_n_out), 32'd1);
    sa.tx_data = 8'h34;
    step();
    chk("t4_ssn_next", 32'(sa.ss_n_out), 32'd0);
    wait_done_a(n);
    sa.start = 1'b0;
    chk("t4_latency", 32'(n), 32'd34);
    chk("t4_rx2", 32'(sa.rx_data), 32'h34);
    step(); step();

    // Asynchronous reset in the middle of bit 4.
    start_a(8'h5A);
    repeat (17) step();
    rst = 1'b1;
    #1;
    chk("t5_ss_n", 32'(sa.ss_n_out), 32'd1);
    chk("t5_sclk", 32'(sa.sclk_out), 32'd0);
    chk("t5_busy", 32'(sa.busy), 32'd0);
    chk("t5_rx", 32'(sa.rx_data), 32'd0);
    step();
    rst = 1'b0;
    step();
    start_a(8'hE7);
    wait_done_a(n);
    chk("t5_latency", 32'(n), 32'd34);
    chk("t5_rx_after", 32'(sa.rx_data), 32'hE7);
    step();

    // CLK_DIV=1 instance, loopback 0xC3.
    r0 = rises_b;
    sb.tx_data = 8'hC3;
    sb.start   = 1'b1;
    step();
    sb.start   = 1'b0;
    n = 0;
    while (!sb.done && n < 200) begin
      step();
      n++;
    end
    chk("t6_latency", 32'(n), 32'd17);
    chk("t6_rx", 32'(sb.rx_data), 32'hC3);
    chk("t6_rises", 32'(rises_b - r0), 32'd8);

    // Random frames with random MISO and stray mid-frame requests.
    mode = 2;
    for (int i = 0; i < 20; i++) begin
      start_a(W'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(1, 30);
        repeat (r) step();
        sa.tx_data = W'($urandom);
        sa.start   = 1'b1;
        step();
        sa.start   = 1'b0;
      end
      wait_done_a(n);
      chk("rnd_timeout", 32'(n < 200), 32'd1);
      repeat ($urandom_range(0, 3)) step();
    end
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
